// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and defaults for the two-master Wishbone arbiter
package wb_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} arb_state_e;
  localparam int MAX_OUTST_DEF = 4;
endpackage

// File: rtl/wishbone_if.sv
// wishbone_if: pipelined Wishbone bundle (master drives request, slave drives response)
interface wishbone_if #(parameter int AW = 32, parameter int DW = 32);
  logic cyc, stb, we, ack, err, stall;
  logic [DW/8-1:0] sel;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_m, data_s;
  modport master (output cyc, stb, we, sel, addr, data_m, input data_s, ack, err, stall);
  modport slave (input cyc, stb, we, sel, addr, data_m, output data_s, ack, err, stall);
endinterface

// File: rtl/wb_arb_rr.sv
// wb_arb_rr: 2-way round-robin picker; priority moves to the loser on each grant
module wb_arb_rr #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic prio;
  always_comb gnt = &req ? (prio ? 2'b10 : 2'b01) : req;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prio <= RR_INIT;
    else if (en && |gnt) prio <= gnt[0];
endmodule

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master pipelined Wishbone arbiter with outstanding-transfer tracking
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int MAX_OUTST = MAX_OUTST_DEF,
  parameter int RR_INIT   = 0
) (
  input logic        clk_i,
  input logic        rst_ni,
  wishbone_if.slave  wb_m0,
  wishbone_if.slave  wb_m1,
  wishbone_if.master wb_s
);
  localparam int CW = $clog2(MAX_OUTST + 1);
  arb_state_e    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    req, gnt;
  logic          own0, own1, own, done, blk, inc, dec;
  assign own0 = state == OWN0;
  assign own1 = state == OWN1;
  assign own  = own0 || own1;
  assign req  = {wb_m1.cyc && wb_m1.stb, wb_m0.cyc && wb_m0.stb};
  assign done = wb_s.ack || wb_s.err;
  // a completion this cycle frees a slot, so a full counter only blocks without one
  assign blk  = cnt == CW'(MAX_OUTST) && !done;
  assign wb_s.cyc    = own1 ? wb_m1.cyc : own0 ? wb_m0.cyc : state == DRAIN;
  assign wb_s.stb    = own && !blk && (own1 ? wb_m1.stb : wb_m0.stb);
  assign wb_s.we     = own && (own1 ? wb_m1.we : wb_m0.we);
  assign wb_s.sel    = own ? (own1 ? wb_m1.sel : wb_m0.sel) : '0;
  assign wb_s.addr   = own1 ? wb_m1.addr : wb_m0.addr;
  assign wb_s.data_m = own1 ? wb_m1.data_m : wb_m0.data_m;
  assign wb_m0.ack    = own0 && wb_s.ack;
  assign wb_m0.err    = own0 && wb_s.err;
  assign wb_m0.stall  = !own0 || wb_s.stall || blk;
  assign wb_m0.data_s = wb_s.data_s;
  assign wb_m1.ack    = own1 && wb_s.ack;
  assign wb_m1.err    = own1 && wb_s.err;
  assign wb_m1.stall  = !own1 || wb_s.stall || blk;
  assign wb_m1.data_s = wb_s.data_s;
  assign inc = wb_s.cyc && wb_s.stb && !wb_s.stall;
  assign dec = done && cnt != '0;
  always_comb cnt_nx = (inc && !dec) ? cnt + 1'b1 : (dec && !inc) ? cnt - 1'b1 : cnt;
  wb_arb_rr #(.RR_INIT(1'(RR_INIT))) u_rr (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .en   (state == IDLE),
    .req  (req),
    .gnt  (gnt)
  );
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = gnt[0] ? OWN0 : gnt[1] ? OWN1 : IDLE;
      OWN0:  if (!wb_m0.cyc) state_nx = cnt_nx == '0 ? IDLE : DRAIN;
      OWN1:  if (!wb_m1.cyc) state_nx = cnt_nx == '0 ? IDLE : DRAIN;
      DRAIN: if (cnt_nx == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: directed self-checking bench for wb_arbiter_2m (MAX_OUTST=2)
module tb_wb_arbiter_2m;
  import wb_arb_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n = 0;
  int errs = 0;
  wishbone_if m0 ();
  wishbone_if m1 ();
  wishbone_if s ();
  wb_arbiter_2m #(.MAX_OUTST(2), .RR_INIT(0)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .wb_m0 (m0),
    .wb_m1 (m1),
    .wb_s  (s)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input int m, input logic c, input logic st, input logic [31:0] a);
    if (m == 0) begin
      m0.cyc = c; m0.stb = st; m0.addr = a;
    end else begin
      m1.cyc = c; m1.stb = st; m1.addr = a;
    end
  endtask
  task automatic sl(input logic a, input logic e, input logic st);
    s.ack = a; s.err = e; s.stall = st;
  endtask
  task automatic clr();
    drv(0, 0, 0, 0);
    drv(1, 0, 0, 0);
    m0.we = 0; m1.we = 0; m0.sel = '1; m1.sel = '1;
    m0.data_m = 32'h0; m1.data_m = 32'h0;
    s.data_s = 32'hD0D0;
    sl(0, 0, 0);
  endtask
  task automatic do_rst();
    rst_n = 0;
    clr();
    tick();
    tick();
    rst_n = 1;
  endtask
  initial begin
    clr();
    #1;
    s.ack = 1;
    #1;
    chk("rst_m0_ack", m0.ack, 0);
    chk("rst_m1_ack", m1.ack, 0);
    chk("rst_m0_stall", m0.stall, 1);
    chk("rst_m1_stall", m1.stall, 1);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_cnt", 32'(dut.cnt), 0);
    s.ack = 0;
    tick(); tick();
    rst_n = 1;
    // single master, three pipelined reads, 1-cycle ack
    tick();
    drv(0, 1, 1, 32'h0);
    #1;
    chk("t1_idle_stb", s.stb, 0);
    chk("t1_idle_stall", m0.stall, 1);
    tick();
    chk("t1_own0", 32'(dut.state), 32'(OWN0));
    chk("t1_s_stb", s.stb, 1);
    chk("t1_s_cyc", s.cyc, 1);
    chk("t1_addr0", s.addr, 32'h0);
    chk("t1_m0_stall", m0.stall, 0);
    chk("t1_m1_stall", m1.stall, 1);
    tick();
    drv(0, 1, 1, 32'h4); sl(1, 0, 0);
    #1;
    chk("t1_ack1", m0.ack, 1);
    chk("t1_m1_noack1", m1.ack, 0);
    chk("t1_cnt1", 32'(dut.cnt), 1);
    chk("t1_addr4", s.addr, 32'h4);
    tick();
    drv(0, 1, 1, 32'h8);
    #1;
    chk("t1_ack2", m0.ack, 1);
    chk("t1_cnt2", 32'(dut.cnt), 1);
    tick();
    drv(0, 1, 0, 32'h8);
    #1;
    chk("t1_ack3", m0.ack, 1);
    chk("t1_m1_noack3", m1.ack, 0);
    tick();
    drv(0, 0, 0, 0); sl(0, 0, 0);
    #1;
    chk("t1_cnt_end", 32'(dut.cnt), 0);
    tick();
    chk("t1_idle", 32'(dut.state), 32'(IDLE));
    chk("t1_idle_cyc", s.cyc, 0);
    // contention, round robin
    do_rst();
    drv(0, 1, 1, 32'h10); drv(1, 1, 1, 32'h20);
    tick();
    chk("t2_own0", 32'(dut.state), 32'(OWN0));
    chk("t2_addr_m0", s.addr, 32'h10);
    chk("t2_m1_stall", m1.stall, 1);
    tick();
    drv(0, 0, 0, 0); sl(1, 0, 0);
    #1;
    chk("t2_m0_ack", m0.ack, 1);
    chk("t2_m1_noack", m1.ack, 0);
    tick();
    sl(0, 0, 0);
    #1;
    chk("t2_idle", 32'(dut.state), 32'(IDLE));
    chk("t2_idle_stb", s.stb, 0);
    tick();
    chk("t2_own1", 32'(dut.state), 32'(OWN1));
    chk("t2_addr_m1", s.addr, 32'h20);
    chk("t2_m0_stall", m0.stall, 1);
    tick();
    drv(1, 0, 0, 0); sl(1, 0, 0);
    #1;
    chk("t2_m1_ack", m1.ack, 1);
    chk("t2_m0_noack", m0.ack, 0);
    tick();
    sl(0, 0, 0);
    drv(0, 1, 1, 32'h30); drv(1, 1, 1, 32'h40);
    #1;
    chk("t2_idle2", 32'(dut.state), 32'(IDLE));
    tick();
    chk("t2_tie_m0", 32'(dut.state), 32'(OWN0));
    chk("t2_tie_addr", s.addr, 32'h30);
    // backpressure with MAX_OUTST=2
    do_rst();
    drv(0, 1, 1, 32'h100);
    tick();
    chk("t3_own0", 32'(dut.state), 32'(OWN0));
    tick();
    drv(0, 1, 1, 32'h104);
    #1;
    chk("t3_stb2", s.stb, 1);
    chk("t3_cnt1", 32'(dut.cnt), 1);
    tick();
    drv(0, 1, 1, 32'h108);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_full_stb", s.stb, 0);
      chk("t3_full_stall", m0.stall, 1);
      chk("t3_full_cnt", 32'(dut.cnt), 2);
      tick();
    end
    sl(1, 0, 0);
    #1;
    chk("t3_pass_stb", s.stb, 1);
    chk("t3_pass_stall", m0.stall, 0);
    chk("t3_pass_ack", m0.ack, 1);
    tick();
    drv(0, 1, 1, 32'h10C); sl(0, 0, 0);
    #1;
    chk("t3_cnt_hold", 32'(dut.cnt), 2);
    chk("t3_stb4", s.stb, 0);
    chk("t3_stall4", m0.stall, 1);
    // abort by m1 with two outstanding
    do_rst();
    drv(1, 1, 1, 32'h200);
    tick();
    chk("t4_own1", 32'(dut.state), 32'(OWN1));
    tick();
    drv(1, 1, 1, 32'h204);
    tick();
    drv(1, 0, 0, 0); drv(0, 1, 1, 32'h300);
    #1;
    chk("t4_cnt2", 32'(dut.cnt), 2);
    chk("t4_abort_stb", s.stb, 0);
    chk("t4_m0_wait", m0.stall, 1);
    tick();
    sl(1, 0, 0);
    #1;
    chk("t4_drain", 32'(dut.state), 32'(DRAIN));
    chk("t4_drain_cyc", s.cyc, 1);
    chk("t4_drain_stb", s.stb, 0);
    chk("t4_late_m0", m0.ack, 0);
    chk("t4_late_m1", m1.ack, 0);
    tick();
    #1;
    chk("t4_drain2", 32'(dut.state), 32'(DRAIN));
    chk("t4_late2_m0", m0.ack, 0);
    chk("t4_late2_m1", m1.ack, 0);
    tick();
    sl(0, 0, 0);
    #1;
    chk("t4_idle", 32'(dut.state), 32'(IDLE));
    chk("t4_cnt0", 32'(dut.cnt), 0);
    tick();
    chk("t4_own0", 32'(dut.state), 32'(OWN0));
    chk("t4_addr", s.addr, 32'h300);
    // error on transfer 2 with a concurrent accepted stb
    do_rst();
    drv(0, 1, 1, 32'h400);
    tick();
    tick();
    drv(0, 1, 1, 32'h404); sl(1, 0, 0);
    tick();
    drv(0, 1, 1, 32'h408); sl(0, 1, 0);
    #1;
    chk("t5_err", m0.err, 1);
    chk("t5_noack", m0.ack, 0);
    chk("t5_m1_err", m1.err, 0);
    chk("t5_stb", s.stb, 1);
    chk("t5_cnt_pre", 32'(dut.cnt), 1);
    tick();
    drv(0, 1, 0, 32'h408); sl(1, 0, 0);
    #1;
    chk("t5_cnt_same", 32'(dut.cnt), 1);
    chk("t5_ack3", m0.ack, 1);
    tick();
    drv(0, 0, 0, 0); sl(0, 0, 0);
    #1;
    chk("t5_cnt0", 32'(dut.cnt), 0);
    tick();
    chk("t5_idle", 32'(dut.state), 32'(IDLE));
    // reset mid-burst
    do_rst();
    drv(0, 1, 1, 32'h500);
    tick();
    tick();
    drv(0, 1, 1, 32'h504);
    tick();
    drv(0, 0, 0, 0);
    #1;
    chk("t6_cnt2", 32'(dut.cnt), 2);
    rst_n = 0;
    #1;
    chk("t6_rst_state", 32'(dut.state), 32'(IDLE));
    chk("t6_rst_cnt", 32'(dut.cnt), 0);
    chk("t6_rst_stall", m0.stall, 1);
    tick();
    rst_n = 1;
    sl(1, 0, 0);
    #1;
    chk("t6_stray_m0", m0.ack, 0);
    chk("t6_stray_m1", m1.ack, 0);
    tick();
    sl(0, 0, 0);
    #1;
    chk("t6_no_underflow", 32'(dut.cnt), 0);
    chk("t6_idle", 32'(dut.state), 32'(IDLE));
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
